// File: rtl/sync_fifo_pkg.sv
// Shared constants, typedefs and flag helper for sync_fifo_v2.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_ADDRWIDTH = 5;
  localparam int unsigned DEFAULT_DATAWIDTH = 16;

  typedef logic [DEFAULT_ADDRWIDTH:0]   ptr_t;
  typedef logic [DEFAULT_ADDRWIDTH:0]   count_t;
  typedef logic [DEFAULT_DATAWIDTH-1:0] word_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

  function automatic fifo_flags_t calc_flags(input int unsigned count,
                                             input int unsigned depth,
                                             input int unsigned afull_thresh,
                                             input int unsigned aempty_thresh);
    fifo_flags_t f;
    f.empty        = (count == 0);
    f.full         = (count == depth);
    f.almost_empty = (count <= aempty_thresh);
    f.almost_full  = (count >= afull_thresh);
    return f;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage: one write port, one registered read port. Only the read
// register is reset; the array itself is never cleared.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int unsigned AddrWidth = DEFAULT_ADDRWIDTH,
  parameter int unsigned DataWidth = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem_q [2**AddrWidth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Holds the last popped word when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with registered status flags and one-cycle read latency.
// Define SYNC_FIFO_V2_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDRWIDTH     = DEFAULT_ADDRWIDTH,
  parameter int unsigned DATAWIDTH     = DEFAULT_DATAWIDTH,
  parameter int unsigned AFULL_THRESH  = (1 << ADDRWIDTH) - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WrEn,
  input  logic [DATAWIDTH-1:0] WriteData,
  input  logic                 RdEn,
  output logic [DATAWIDTH-1:0] ReadData,
  output logic                 ReadValid,
  output logic                 empty,
  output logic                 full,
  output logic                 almostEmpty,
  output logic                 almostFull,
  output logic [ADDRWIDTH:0]   fillCount
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int unsigned DEPTH = 1 << ADDRWIDTH;

  if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_thresh_check
    $fatal(1, "sync_fifo_v2: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [ADDRWIDTH:0] wptr_q, wptr_d;
  logic [ADDRWIDTH:0] rptr_q, rptr_d;
  logic [ADDRWIDTH:0] count_q, count_d;
  fifo_flags_t        flags_q, flags_d;
  logic               valid_q;
  logic               wr_accept, rd_accept;

  always_comb begin
    wr_accept = WrEn & ~flags_q.full;
    rd_accept = RdEn & ~flags_q.empty;
    wptr_d    = wptr_q + {{ADDRWIDTH{1'b0}}, wr_accept};
    rptr_d    = rptr_q + {{ADDRWIDTH{1'b0}}, rd_accept};
    // Modular difference stays correct across pointer wrap.
    count_d   = wptr_d - rptr_d;
    flags_d   = calc_flags(32'(count_d), DEPTH, AFULL_THRESH, AEMPTY_THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      flags_q <= calc_flags(0, DEPTH, AFULL_THRESH, AEMPTY_THRESH);
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      flags_q <= flags_d;
      valid_q <= rd_accept;
    end
  end

  fifo_mem_2p #(
    .AddrWidth(ADDRWIDTH),
    .DataWidth(DATAWIDTH)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_accept & ~reset),
    .wr_addr(wptr_q[ADDRWIDTH-1:0]),
    .wr_data(WriteData),
    .rd_en  (rd_accept),
    .rd_addr(rptr_q[ADDRWIDTH-1:0]),
    .rd_data(ReadData)
  );

  assign ReadValid   = valid_q;
  assign fillCount   = count_q;
  assign empty       = flags_q.empty;
  assign full        = flags_q.full;
  assign almostEmpty = flags_q.almost_empty;
  assign almostFull  = flags_q.almost_full;

`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (WrEn & flags_q.full);
      underflow_q <= underflow_q | (RdEn & flags_q.empty);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: queue-based reference model checked every cycle,
// plus directed literal checks on the key scenarios.
module tb_sync_fifo_v2;

  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 16;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned AFULL  = 28;
  localparam int unsigned AEMPTY = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          WrEn, RdEn;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          ReadValid, empty, full, almostEmpty, almostFull;
  logic [AW:0]   fillCount;
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_v2 dut (
    .clk        (clk),
    .reset      (reset),
    .WrEn       (WrEn),
    .WriteData  (WriteData),
    .RdEn       (RdEn),
    .ReadData   (ReadData),
    .ReadValid  (ReadValid),
    .empty      (empty),
    .full       (full),
    .almostEmpty(almostEmpty),
    .almostFull (almostFull),
    .fillCount  (fillCount)
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  // Reference model: contents as a queue, updated from the inputs at each edge.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata = '0;
  bit            m_valid = 1'b0;
  bit            m_over  = 1'b0;
  bit            m_under = 1'b0;

  always @(posedge clk) begin
    int n;
    n = mq.size();
    if (reset) begin
      mq.delete();
      m_valid = 1'b0;
      m_rdata = '0;
      m_over  = 1'b0;
      m_under = 1'b0;
    end else begin
      if (WrEn && n == DEPTH) m_over = 1'b1;
      if (RdEn && n == 0) m_under = 1'b1;
      m_valid = RdEn && n != 0;
      if (m_valid) m_rdata = mq.pop_front();
      if (WrEn && n != DEPTH) mq.push_back(WriteData);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      chk("model fillCount", 32'(fillCount), n);
      chk("model empty", 32'(empty), 32'(n == 0));
      chk("model full", 32'(full), 32'(n == DEPTH));
      chk("model almostEmpty", 32'(almostEmpty), 32'(n <= AEMPTY));
      chk("model almostFull", 32'(almostFull), 32'(n >= AFULL));
      chk("model ReadValid", 32'(ReadValid), 32'(m_valid));
      chk("model ReadData", 32'(ReadData), 32'(m_rdata));
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
      chk("model overflow", 32'(overflow), 32'(m_over));
      chk("model underflow", 32'(underflow), 32'(m_under));
`endif
    end
  end

  // Inputs held across one rising edge; returns 1 time unit after it.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    WrEn      = w;
    WriteData = d;
    RdEn      = r;
    @(posedge clk);
    #1;
    WrEn = 1'b0;
    RdEn = 1'b0;
  endtask

  initial begin
    reset = 1'b1; WrEn = 1'b0; RdEn = 1'b0; WriteData = '0;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset fillCount", 32'(fillCount), 0);
    chk("reset empty", 32'(empty), 1);
    chk("reset almostEmpty", 32'(almostEmpty), 1);
    chk("reset ReadData", 32'(ReadData), 0);

    // Fill with 0x0001..0x0020.
    for (int i = 1; i <= 32; i++) begin
      step(1, DW'(i), 0);
      if (i == 27) chk("almostFull at 27", 32'(almostFull), 0);
      if (i == 28) chk("almostFull at 28", 32'(almostFull), 1);
      if (i == 31) chk("full at 31", 32'(full), 0);
    end
    chk("full at 32", 32'(full), 1);
    chk("fillCount at 32", 32'(fillCount), 32);

    step(1, 16'hDEAD, 0);
    chk("overflow write fillCount", 32'(fillCount), 32);
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    chk("overflow set", 32'(overflow), 1);
`endif

    for (int i = 1; i <= 32; i++) begin
      step(0, 0, 1);
      chk("drain ReadValid", 32'(ReadValid), 1);
      chk("drain ReadData", 32'(ReadData), i);
    end
    chk("drained empty", 32'(empty), 1);
    step(0, 0, 0);
    chk("idle ReadValid", 32'(ReadValid), 0);
    chk("idle ReadData hold", 32'(ReadData), 32);

    step(0, 0, 1);
    chk("underflow ReadValid", 32'(ReadValid), 0);
    chk("underflow fillCount", 32'(fillCount), 0);
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    chk("underflow set", 32'(underflow), 1);
`endif

    // Steady state at fillCount=10 with pointers wrapping.
    for (int i = 0; i < 10; i++) step(1, DW'(100 + i), 0);
    for (int k = 0; k < 100; k++) begin
      step(1, DW'(200 + k), 1);
      chk("steady fillCount", 32'(fillCount), 10);
      if (k < 10) chk("steady ReadData", 32'(ReadData), 100 + k);
      else chk("steady ReadData", 32'(ReadData), 200 + k - 10);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    chk("steady drained ReadData", 32'(ReadData), 299);

    step(1, 16'hA5A5, 0);
    step(0, 0, 1);
    chk("A5A5 ReadData", 32'(ReadData), 32'hA5A5);
    chk("A5A5 ReadValid", 32'(ReadValid), 1);
    chk("A5A5 empty", 32'(empty), 1);

    // Read and write on an empty FIFO: no fall-through.
    step(1, 16'h0777, 1);
    chk("empty rw ReadValid", 32'(ReadValid), 0);
    chk("empty rw fillCount", 32'(fillCount), 1);
    step(0, 0, 1);
    chk("empty rw ReadData", 32'(ReadData), 32'h0777);

    // Read and write on a full FIFO: write dropped, read proceeds.
    for (int i = 1; i <= 32; i++) step(1, DW'(300 + i), 0);
    step(1, 16'hBEEF, 1);
    chk("full rw fillCount", 32'(fillCount), 31);
    chk("full rw ReadData", 32'(ReadData), 301);
    for (int i = 0; i < 14; i++) step(0, 0, 1);
    chk("pre-reset fillCount", 32'(fillCount), 17);

    reset = 1'b1;
    step(1, 16'h1234, 1);
    reset = 1'b0;
    chk("mid reset fillCount", 32'(fillCount), 0);
    chk("mid reset empty", 32'(empty), 1);
    chk("mid reset ReadValid", 32'(ReadValid), 0);
`ifdef SYNC_FIFO_V2_ERR_FLAGS_EN
    chk("mid reset overflow", 32'(overflow), 0);
    chk("mid reset underflow", 32'(underflow), 0);
`endif
    step(0, 0, 0);
    step(0, 0, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
